alu_share_ctrl: RTL and testbench

//  Shares one combinational ALU (one-hot 7-bit alu_sel, 32-bit a/b, 32-bit result, 4-bit NZCV flags) between two requesters.

---
 rtl/alu_pkg.sv | 31 +++
 rtl/alu_share_ctrl_chk.sv | 34 +++
 rtl/rr_arb2.sv | 53 +++++
 rtl/alu_share_ctrl.sv | 197 +++++++++++++++++++
 tb/tb_alu_share_ctrl.sv | 339 +++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/alu_pkg.sv
// Shared definitions for the ALU sharing controller: one-hot ALU selects,
// NZCV flag bit positions and the controller FSM state encoding.
package alu_pkg;

  localparam int ALU_OP_W = 7;
  localparam int FLAG_W   = 4;

  localparam logic [ALU_OP_W-1:0] ALU_ADD = 7'b000_0001;
  localparam logic [ALU_OP_W-1:0] ALU_SUB = 7'b000_0010;
  localparam logic [ALU_OP_W-1:0] ALU_CMP = 7'b000_0100;
  localparam logic [ALU_OP_W-1:0] ALU_AND = 7'b000_1000;
  localparam logic [ALU_OP_W-1:0] ALU_ORR = 7'b001_0000;
  localparam logic [ALU_OP_W-1:0] ALU_EOR = 7'b010_0000;
  localparam logic [ALU_OP_W-1:0] ALU_MOV = 7'b100_0000;

  localparam int FLG_Z = 3;
  localparam int FLG_N = 2;
  localparam int FLG_C = 1;
  localparam int FLG_V = 0;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  function automatic logic op_is_onehot(input logic [ALU_OP_W-1:0] op);
    return (op != 7'b000_0000) && ((op & (op - 7'b000_0001)) == 7'b000_0000);
  endfunction

endpackage

// File: rtl/alu_share_ctrl_chk.sv
// Protocol properties of alu_share_ctrl: exclusive grants and responses,
// legal ALU select, and response payload held stable under backpressure.
module alu_share_ctrl_chk #(
  parameter int DATA_W = 32
) (
  input logic              clk,
  input logic              reset_n,
  input logic              req0_ready,
  input logic              req1_ready,
  input logic              rsp0_valid,
  input logic              rsp0_ready,
  input logic              rsp1_valid,
  input logic              rsp1_ready,
  input logic [6:0]        alu_sel,
  input logic [DATA_W-1:0] rsp_data,
  input logic [3:0]        rsp_flags
);

  a_one_grant: assert property (@(posedge clk) disable iff (!reset_n)
    !(req0_ready && req1_ready));

  a_one_rsp: assert property (@(posedge clk) disable iff (!reset_n)
    !(rsp0_valid && rsp1_valid));

  a_sel_legal: assert property (@(posedge clk) disable iff (!reset_n)
    $onehot0(alu_sel));

  a_hold0: assert property (@(posedge clk) disable iff (!reset_n)
    (rsp0_valid && !rsp0_ready) |=> (rsp0_valid && $stable(rsp_data) && $stable(rsp_flags)));

  a_hold1: assert property (@(posedge clk) disable iff (!reset_n)
    (rsp1_valid && !rsp1_ready) |=> (rsp1_valid && $stable(rsp_data) && $stable(rsp_flags)));

endmodule

// File: rtl/rr_arb2.sv
// Two-way arbiter: round-robin with a one-bit tie pointer, or fixed priority
// to req[0]. The pointer moves to the side that was not granted on accept.
module rr_arb2 #(
  parameter bit FIXED_PRI = 1'b0
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [1:0] req,
  input  logic       accept,
  output logic [1:0] grant
);

  logic ptr_q;
  logic ptr_d;

  // ptr_q = 1 means req[1] wins a tie.
  always_comb begin
    grant = 2'b00;
    if (FIXED_PRI) begin
      if (req[0]) begin
        grant = 2'b01;
      end else if (req[1]) begin
        grant = 2'b10;
      end else begin
        grant = 2'b00;
      end
    end else begin
      case (req)
        2'b01:   grant = 2'b01;
        2'b10:   grant = 2'b10;
        2'b11:   grant = ptr_q ? 2'b10 : 2'b01;
        default: grant = 2'b00;
      endcase
    end
  end

  always_comb begin
    if (accept) begin
      ptr_d = grant[0];
    end else begin
      ptr_d = ptr_q;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ptr_q <= 1'b0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

endmodule

// File: rtl/alu_share_ctrl.sv
// Shares one external combinational ALU between two requesters: arbitrates,
// registers operands for a single EXEC cycle, returns the result on the
// owner's response port and owns the architectural NZCV register.
module alu_share_ctrl
  import alu_pkg::*;
#(
  parameter int DATA_W    = 32,
  parameter bit FIXED_PRI = 1'b0
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                req0_valid,
  output logic                req0_ready,
  input  logic [ALU_OP_W-1:0] req0_op,
  input  logic [DATA_W-1:0]   req0_a,
  input  logic [DATA_W-1:0]   req0_b,
  input  logic                req0_setf,
  input  logic                req1_valid,
  output logic                req1_ready,
  input  logic [ALU_OP_W-1:0] req1_op,
  input  logic [DATA_W-1:0]   req1_a,
  input  logic [DATA_W-1:0]   req1_b,
  input  logic                req1_setf,
  output logic                rsp0_valid,
  input  logic                rsp0_ready,
  output logic                rsp1_valid,
  input  logic                rsp1_ready,
  output logic [DATA_W-1:0]   rsp_data,
  output logic [FLAG_W-1:0]   rsp_flags,
  output logic                rsp_err,
  output logic [FLAG_W-1:0]   flags_q,
  output logic [DATA_W-1:0]   alu_a,
  output logic [DATA_W-1:0]   alu_b,
  output logic [ALU_OP_W-1:0] alu_sel,
  input  logic [DATA_W-1:0]   alu_data,
  input  logic [FLAG_W-1:0]   alu_flag
);

  state_e              state_q, state_d;
  logic                owner_q, owner_d;
  logic [DATA_W-1:0]   a_q, a_d;
  logic [DATA_W-1:0]   b_q, b_d;
  logic [ALU_OP_W-1:0] sel_q, sel_d;
  logic                setf_q, setf_d;
  logic [DATA_W-1:0]   data_q, data_d;
  logic [FLAG_W-1:0]   rflags_q, rflags_d;
  logic [FLAG_W-1:0]   flags_d;
  logic                err_q, err_d;
  logic                rsp0_valid_q, rsp0_valid_d;
  logic                rsp1_valid_q, rsp1_valid_d;

  logic [1:0]          arb_req;
  logic [1:0]          grant;
  logic                accept;
  logic                rsp_hs;
  logic [ALU_OP_W-1:0] win_op;
  logic [DATA_W-1:0]   win_a;
  logic [DATA_W-1:0]   win_b;
  logic                win_setf;

  // Requests are only visible to the arbiter while no op is in flight.
  assign arb_req = (state_q == ST_IDLE) ? {req1_valid, req0_valid} : 2'b00;
  assign accept  = (grant != 2'b00);

  rr_arb2 #(
    .FIXED_PRI(FIXED_PRI)
  ) u_arb (
    .clk    (clk),
    .reset_n(reset_n),
    .req    (arb_req),
    .accept (accept),
    .grant  (grant)
  );

  assign req0_ready = grant[0] & reset_n;
  assign req1_ready = grant[1] & reset_n;
  assign rsp_hs     = owner_q ? (rsp1_valid_q & rsp1_ready) : (rsp0_valid_q & rsp0_ready);

  assign rsp0_valid = rsp0_valid_q;
  assign rsp1_valid = rsp1_valid_q;
  assign rsp_data   = data_q;
  assign rsp_flags  = rflags_q;
  assign rsp_err    = err_q;
  assign alu_a      = a_q;
  assign alu_b      = b_q;
  assign alu_sel    = sel_q;

  always_comb begin
    if (grant[1]) begin
      win_op   = req1_op;
      win_a    = req1_a;
      win_b    = req1_b;
      win_setf = req1_setf;
    end else begin
      win_op   = req0_op;
      win_a    = req0_a;
      win_b    = req0_b;
      win_setf = req0_setf;
    end
  end

  // sel_q is non-zero only during EXEC, and only for a legal op.
  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    a_d          = a_q;
    b_d          = b_q;
    sel_d        = sel_q;
    setf_d       = setf_q;
    data_d       = data_q;
    rflags_d     = rflags_q;
    flags_d      = flags_q;
    err_d        = err_q;
    rsp0_valid_d = rsp0_valid_q;
    rsp1_valid_d = rsp1_valid_q;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          owner_d = grant[1];
          a_d     = win_a;
          b_d     = win_b;
          setf_d  = win_setf;
          sel_d   = op_is_onehot(win_op) ? win_op : 7'b000_0000;
          state_d = ST_EXEC;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_EXEC: begin
        if (sel_q != 7'b000_0000) begin
          data_d   = alu_data;
          rflags_d = alu_flag;
          err_d    = 1'b0;
          if (setf_q || (sel_q == ALU_CMP)) begin
            flags_d = alu_flag;
          end else begin
            flags_d = flags_q;
          end
        end else begin
          data_d   = {DATA_W{1'b0}};
          rflags_d = 4'b0000;
          err_d    = 1'b1;
        end
        sel_d        = 7'b000_0000;
        rsp0_valid_d = ~owner_q;
        rsp1_valid_d = owner_q;
        state_d      = ST_RESP;
      end
      ST_RESP: begin
        if (rsp_hs) begin
          rsp0_valid_d = 1'b0;
          rsp1_valid_d = 1'b0;
          state_d      = ST_IDLE;
        end else begin
          state_d = ST_RESP;
        end
      end
      default: begin
        sel_d        = 7'b000_0000;
        rsp0_valid_d = 1'b0;
        rsp1_valid_d = 1'b0;
        state_d      = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= ST_IDLE;
      owner_q      <= 1'b0;
      a_q          <= {DATA_W{1'b0}};
      b_q          <= {DATA_W{1'b0}};
      sel_q        <= 7'b000_0000;
      setf_q       <= 1'b0;
      data_q       <= {DATA_W{1'b0}};
      rflags_q     <= 4'b0000;
      flags_q      <= 4'b0000;
      err_q        <= 1'b0;
      rsp0_valid_q <= 1'b0;
      rsp1_valid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      a_q          <= a_d;
      b_q          <= b_d;
      sel_q        <= sel_d;
      setf_q       <= setf_d;
      data_q       <= data_d;
      rflags_q     <= rflags_d;
      flags_q      <= flags_d;
      err_q        <= err_d;
      rsp0_valid_q <= rsp0_valid_d;
      rsp1_valid_q <= rsp1_valid_d;
    end
  end

endmodule

// File: tb/tb_alu_share_ctrl.sv
// Scoreboard bench for alu_share_ctrl: an ALU model closes the loop, a monitor
// checks arbitration, responses and flags against a transaction-level model.
module tb_alu_share_ctrl;
  import alu_pkg::*;

  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  logic        r0v, r0r, r1v, r1r, r0s, r1s;
  logic [6:0]  r0op, r1op;
  logic [31:0] r0a, r0b, r1a, r1b;
  logic        s0v, s0r, s1v, s1r, rsp_err;
  logic [31:0] rsp_data, alu_a, alu_b, alu_data;
  logic [3:0]  rsp_flags, flags_q, alu_flag;
  logic [6:0]  alu_sel;

  logic        fp_one, fp_r0r, fp_r1r, fp_s0v, fp_s1v, fp_err;
  logic [31:0] fp_data, fp_alu_a, fp_alu_b, fp_alu_data;
  logic [3:0]  fp_flags, fp_fq, fp_alu_flag;
  logic [6:0]  fp_alu_sel;

  int n_chk = 0;
  int n_fail = 0;

  // Reference ALU: ADD/SUB/CMP/logic/MOV with NZCV; C on SUB/CMP means borrow.
  function automatic logic [35:0] alu_ref(input logic [6:0] sel, input logic [31:0] a, input logic [31:0] b);
    logic [32:0] w;
    logic [31:0] r;
    logic [31:0] d;
    logic [3:0]  f;
    r = 32'd0; d = 32'd0; f = 4'd0; w = 33'd0;
    case (sel)
      ALU_ADD: begin
        w = {1'b0, a} + {1'b0, b};
        r = w[31:0];
        f[FLG_C] = w[32];
        f[FLG_V] = (a[31] == b[31]) && (r[31] != a[31]);
        d = r;
      end
      ALU_SUB, ALU_CMP: begin
        r = a - b;
        f[FLG_C] = (a < b);
        f[FLG_V] = (a[31] != b[31]) && (r[31] != a[31]);
        d = (sel == ALU_CMP) ? 32'd0 : r;
      end
      ALU_AND: begin r = a & b; d = r; end
      ALU_ORR: begin r = a | b; d = r; end
      ALU_EOR: begin r = a ^ b; d = r; end
      ALU_MOV: begin r = b; d = r; end
      default: begin r = 32'd0; d = 32'd0; end
    endcase
    if ($onehot(sel)) begin
      f[FLG_Z] = (r == 32'd0);
      f[FLG_N] = r[31];
    end
    return {d, f};
  endfunction

  assign {alu_data, alu_flag}       = alu_ref(alu_sel, alu_a, alu_b);
  assign {fp_alu_data, fp_alu_flag} = alu_ref(fp_alu_sel, fp_alu_a, fp_alu_b);

  alu_share_ctrl #(.DATA_W(32), .FIXED_PRI(1'b0)) dut (
    .clk(clk), .reset_n(reset_n),
    .req0_valid(r0v), .req0_ready(r0r), .req0_op(r0op), .req0_a(r0a), .req0_b(r0b), .req0_setf(r0s),
    .req1_valid(r1v), .req1_ready(r1r), .req1_op(r1op), .req1_a(r1a), .req1_b(r1b), .req1_setf(r1s),
    .rsp0_valid(s0v), .rsp0_ready(s0r), .rsp1_valid(s1v), .rsp1_ready(s1r),
    .rsp_data(rsp_data), .rsp_flags(rsp_flags), .rsp_err(rsp_err), .flags_q(flags_q),
    .alu_a(alu_a), .alu_b(alu_b), .alu_sel(alu_sel), .alu_data(alu_data), .alu_flag(alu_flag)
  );

  alu_share_ctrl #(.DATA_W(32), .FIXED_PRI(1'b1)) dut_fp (
    .clk(clk), .reset_n(reset_n),
    .req0_valid(fp_one), .req0_ready(fp_r0r), .req0_op(ALU_ADD), .req0_a(32'd1), .req0_b(32'd2), .req0_setf(1'b1),
    .req1_valid(fp_one), .req1_ready(fp_r1r), .req1_op(ALU_SUB), .req1_a(32'd3), .req1_b(32'd4), .req1_setf(1'b1),
    .rsp0_valid(fp_s0v), .rsp0_ready(fp_one), .rsp1_valid(fp_s1v), .rsp1_ready(fp_one),
    .rsp_data(fp_data), .rsp_flags(fp_flags), .rsp_err(fp_err), .flags_q(fp_fq),
    .alu_a(fp_alu_a), .alu_b(fp_alu_b), .alu_sel(fp_alu_sel), .alu_data(fp_alu_data), .alu_flag(fp_alu_flag)
  );

  alu_share_ctrl_chk #(.DATA_W(32)) u_chk (
    .clk(clk), .reset_n(reset_n), .req0_ready(r0r), .req1_ready(r1r),
    .rsp0_valid(s0v), .rsp0_ready(s0r), .rsp1_valid(s1v), .rsp1_ready(s1r),
    .alu_sel(alu_sel), .rsp_data(rsp_data), .rsp_flags(rsp_flags)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  typedef struct {
    logic        owner;
    logic [31:0] data;
    logic [3:0]  flags;
    logic        err;
    logic [3:0]  fq_after;
  } exp_t;

  exp_t        sb[$];
  bit          grants[$];
  bit          in_flight = 1'b0;
  bit          ptr = 1'b0;
  bit          rsp_seen = 1'b0;
  logic [3:0]  flags_cur = 4'd0;
  int          cyc = 0;
  int          acc_cyc = 0;
  int          fp_cnt = 0;

  // Monitor: arbitration model, scoreboard pop/compare, acceptance push.
  always @(negedge clk) begin
    exp_t it;
    logic exp_r0, exp_r1, own, legal;
    logic [6:0] op;
    logic [35:0] res;
    cyc++;
    if (!reset_n) begin
      sb.delete();
      grants.delete();
      in_flight = 1'b0;
      ptr       = 1'b0;
      rsp_seen  = 1'b0;
      flags_cur = 4'd0;
    end else begin
      exp_r0 = !in_flight && r0v && (!r1v || !ptr);
      exp_r1 = !in_flight && r1v && (!r0v || ptr);
      chk("req0_ready", 32'(r0r), 32'(exp_r0));
      chk("req1_ready", 32'(r1r), 32'(exp_r1));
      if (!in_flight) chk("flags_q_idle", 32'(flags_q), 32'(flags_cur));
      if (s0v || s1v) begin
        if (sb.size() == 0) begin
          chk("rsp_unexpected", 32'({s1v, s0v}), 32'd0);
        end else begin
          it = sb[0];
          chk("rsp_owner", 32'({s1v, s0v}), it.owner ? 32'd2 : 32'd1);
          chk("rsp_data", rsp_data, it.data);
          chk("rsp_flags", 32'(rsp_flags), 32'(it.flags));
          chk("rsp_err", 32'(rsp_err), 32'(it.err));
          chk("flags_q_rsp", 32'(flags_q), 32'(it.fq_after));
          if (!rsp_seen) begin
            chk("latency", 32'(cyc - acc_cyc), 32'd2);
            rsp_seen = 1'b1;
          end
          if ((it.owner && s1r) || (!it.owner && s0r)) begin
            void'(sb.pop_front());
            in_flight = 1'b0;
            rsp_seen  = 1'b0;
            flags_cur = it.fq_after;
          end
        end
      end else if (in_flight && !rsp_seen) begin
        chk("rsp_not_late", 32'((cyc - acc_cyc) < 2), 32'd1);
      end
      if ((r0v && r0r) || (r1v && r1r)) begin
        own   = r1v && r1r;
        op    = own ? r1op : r0op;
        res   = own ? alu_ref(r1op, r1a, r1b) : alu_ref(r0op, r0a, r0b);
        legal = $onehot(op);
        it.owner = own;
        if (legal) begin
          it.data     = res[35:4];
          it.flags    = res[3:0];
          it.err      = 1'b0;
          it.fq_after = ((own ? r1s : r0s) || op == ALU_CMP) ? res[3:0] : flags_cur;
        end else begin
          it.data     = 32'd0;
          it.flags    = 4'd0;
          it.err      = 1'b1;
          it.fq_after = flags_cur;
        end
        sb.push_back(it);
        grants.push_back(own);
        in_flight = 1'b1;
        acc_cyc   = cyc;
        ptr       = !own;
      end
    end
  end

  // Fixed-priority instance: req1 must never be served while req0 is always valid.
  always @(negedge clk) begin
    if (reset_n) begin
      chk("fp_req1_ready", 32'(fp_r1r), 32'd0);
      chk("fp_rsp1_valid", 32'(fp_s1v), 32'd0);
      if (fp_s0v) fp_cnt++;
    end
  end

  task automatic rand_req(output logic [6:0] op, output logic [31:0] a, output logic [31:0] b, output logic s);
    if ($urandom_range(0, 9) == 0) op = 7'($urandom_range(0, 127));
    else op = 7'b000_0001 << $urandom_range(0, 6);
    a = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 15)) : $urandom;
    b = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 15)) : $urandom;
    s = 1'($urandom_range(0, 1));
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_req_ready"}, 32'({r1r, r0r}), 32'd0);
    chk({tag, "_rsp_valid"}, 32'({s1v, s0v}), 32'd0);
    chk({tag, "_rsp_data"}, rsp_data, 32'd0);
    chk({tag, "_rsp_flags_err"}, 32'({rsp_flags, rsp_err}), 32'd0);
    chk({tag, "_flags_q"}, 32'(flags_q), 32'd0);
    chk({tag, "_alu_sel"}, 32'(alu_sel), 32'd0);
    chk({tag, "_alu_ab"}, alu_a | alu_b, 32'd0);
  endtask

  // One directed op on requester n; response held for 'hold' extra cycles.
  task automatic issue(input bit n, input logic [6:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic s, input int hold, input bit other_v,
                       output logic [31:0] d, output logic [3:0] f, output logic e);
    bit ok;
    d = 32'd0; f = 4'd0; e = 1'b0;
    @(posedge clk); #1;
    r0v = 1'b0; r1v = 1'b0; s0r = 1'b0; s1r = 1'b0;
    if (n) begin r1v = 1'b1; r1op = op; r1a = a; r1b = b; r1s = s; end
    else begin r0v = 1'b1; r0op = op; r0a = a; r0b = b; r0s = s; end
    ok = 1'b0;
    for (int k = 0; k < 20 && !ok; k++) begin
      @(negedge clk);
      ok = n ? r1r : r0r;
    end
    chk("accept_timeout", 32'(ok), 32'd1);
    @(posedge clk); #1;
    r0v = other_v & n;
    r1v = other_v & !n;
    ok = 1'b0;
    for (int k = 0; k < 20 && !ok; k++) begin
      @(negedge clk);
      ok = n ? s1v : s0v;
    end
    chk("rsp_timeout", 32'(ok), 32'd1);
    d = rsp_data; f = rsp_flags; e = rsp_err;
    repeat (hold) @(negedge clk);
    @(posedge clk); #1;
    r0v = 1'b0; r1v = 1'b0;
    if (n) s1r = 1'b1; else s0r = 1'b1;
    @(posedge clk); #1;
    s0r = 1'b0; s1r = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected $finish");
    $fatal(1);
  end

  initial begin
    logic [31:0] d;
    logic [3:0]  f;
    logic        e;
    bit          ok;
    reset_n = 1'b0; fp_one = 1'b1;
    r0v = 1'b0; r1v = 1'b0; s0r = 1'b0; s1r = 1'b0;
    r0op = 7'd0; r1op = 7'd0; r0a = 32'd0; r0b = 32'd0; r1a = 32'd0; r1b = 32'd0; r0s = 1'b0; r1s = 1'b0;
    repeat (3) @(posedge clk); #1;
    chk_zero("reset");
    reset_n = 1'b1;

    issue(1'b0, ALU_ADD, 32'd5, 32'd7, 1'b1, 0, 1'b0, d, f, e);
    chk("t1_data", d, 32'd12);
    chk("t1_flags", 32'(f), 32'd0);
    chk("t1_flags_q", 32'(flags_q), 32'd0);

    issue(1'b1, ALU_CMP, 32'd9, 32'd9, 1'b0, 0, 1'b0, d, f, e);
    chk("t2_data", d, 32'd0);
    chk("t2_flags", 32'(f), 32'b1000);
    chk("t2_flags_q", 32'(flags_q), 32'b1000);
    issue(1'b0, ALU_AND, 32'hFF, 32'h8000_0001, 1'b0, 0, 1'b0, d, f, e);
    chk("t2_and_data", d, 32'd1);
    chk("t2_and_flags_q", 32'(flags_q), 32'b1000);

    issue(1'b1, 7'b000_0011, 32'd3, 32'd4, 1'b1, 0, 1'b0, d, f, e);
    chk("t5_err", 32'(e), 32'd1);
    chk("t5_data_flags", d | 32'(f), 32'd0);
    chk("t5_flags_q", 32'(flags_q), 32'b1000);

    issue(1'b0, ALU_SUB, 32'd3, 32'd10, 1'b1, 5, 1'b1, d, f, e);
    chk("t4_data", d, 32'hFFFF_FFF9);
    chk("t4_flags", 32'(f), 32'b0110);
    chk("t4_flags_q", 32'(flags_q), 32'b0110);

    // Reset while the op is in EXEC.
    @(posedge clk); #1;
    r0op = ALU_ADD; r0a = 32'hFFFF_FFFF; r0b = 32'd1; r0s = 1'b1; r0v = 1'b1; s0r = 1'b1;
    ok = 1'b0;
    for (int k = 0; k < 20 && !ok; k++) begin
      @(negedge clk);
      ok = r0r;
    end
    chk("t6_accept", 32'(ok), 32'd1);
    @(posedge clk); #1;
    r0v = 1'b0;
    #2 reset_n = 1'b0;
    #1 chk_zero("t6_rst");
    @(posedge clk); @(posedge clk); #1;
    reset_n = 1'b1;
    repeat (5) begin
      @(negedge clk);
      chk("t6_no_stale", 32'({s1v, s0v}), 32'd0);
    end

    // Contention: both valid continuously from a fresh reset.
    @(posedge clk); #1;
    r0v = 1'b1; r1v = 1'b1; s0r = 1'b1; s1r = 1'b1;
    repeat (16) begin
      rand_req(r0op, r0a, r0b, r0s);
      rand_req(r1op, r1a, r1b, r1s);
      @(posedge clk); #1;
    end
    r0v = 1'b0; r1v = 1'b0;
    repeat (5) @(posedge clk);
    chk("t3_grant_count", 32'(grants.size() >= 4), 32'd1);
    if (grants.size() >= 4) begin
      for (int i = 0; i < 4; i++) chk("t3_grant_order", 32'(grants[i]), 32'(i % 2));
    end

    // Random traffic with random response backpressure.
    repeat (600) begin
      @(posedge clk); #1;
      r0v = ($urandom_range(0, 9) < 7);
      r1v = ($urandom_range(0, 9) < 7);
      rand_req(r0op, r0a, r0b, r0s);
      rand_req(r1op, r1a, r1b, r1s);
      s0r = ($urandom_range(0, 9) < 7);
      s1r = ($urandom_range(0, 9) < 7);
    end
    r0v = 1'b0; r1v = 1'b0; s0r = 1'b1; s1r = 1'b1;
    repeat (10) @(posedge clk);
    chk("drain_empty", 32'(sb.size()), 32'd0);
    chk("fp_req0_served", 32'(fp_cnt > 20), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
